// File: rtl/voice_allocator_if.sv
// Event handshake from the front end and per-voice gate/increment outputs to the WaveGen bank.
interface voice_allocator_if #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_WIDTH = 7,
    parameter int INCR_WIDTH = 8
);
    logic                             EventValid;
    logic                             EventReady;
    logic                             EventOn;
    logic [NOTE_WIDTH-1:0]            EventNote;
    logic [INCR_WIDTH-1:0]            EventIncr;
    logic [NUM_VOICES-1:0]            GateOpen;
    logic [NUM_VOICES-1:0]            GateClose;
    logic [NUM_VOICES*INCR_WIDTH-1:0] VoiceIncr;
    logic [NUM_VOICES-1:0]            VoiceActive;
    logic                             Overflow;

    modport master (
        output EventValid, EventOn, EventNote, EventIncr,
        input  EventReady, GateOpen, GateClose, VoiceIncr, VoiceActive, Overflow
    );

    modport slave (
        input  EventValid, EventOn, EventNote, EventIncr,
        output EventReady, GateOpen, GateClose, VoiceIncr, VoiceActive, Overflow
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans one voice per cycle, then retriggers, allocates or drops each event.
// Define VOICE_STEAL_EN to steal the oldest voice (close, wait STEAL_GAP, reopen) when all voices are busy.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_WIDTH = 7,
    parameter int INCR_WIDTH = 8,
    parameter int AGE_WIDTH  = 4,
    parameter int STEAL_GAP  = 2
) (
    input logic             Clock,
    input logic             Reset,
    voice_allocator_if.slave bus
);
    localparam int IW = $clog2(NUM_VOICES);
    localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN
`ifdef VOICE_STEAL_EN
        , STEAL_WAIT
`endif
    } state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic                   lat_on;
    logic [NOTE_WIDTH-1:0]  lat_note;
    logic [INCR_WIDTH-1:0]  lat_incr;

    logic [NUM_VOICES-1:0]  active;
    logic [NOTE_WIDTH-1:0]  note [NUM_VOICES];
    logic [INCR_WIDTH-1:0]  incr [NUM_VOICES];
    logic [AGE_WIDTH-1:0]   age  [NUM_VOICES];

    logic                   m_found, f_found, o_found;
    logic [IW-1:0]          m_idx, f_idx, o_idx;
    logic                   m_found_n, f_found_n, o_found_n;
    logic [IW-1:0]          m_idx_n, f_idx_n, o_idx_n;

    logic [NUM_VOICES-1:0]  gate_open, gate_close;
    logic                   overflow;
    logic [NUM_VOICES*INCR_WIDTH-1:0] incr_flat;

    logic                   open_en, close_en, ovf_en;
    logic [IW-1:0]          open_idx, close_idx;

`ifdef VOICE_STEAL_EN
    localparam int GW = $clog2(STEAL_GAP + 1);
    logic [IW-1:0]          victim;
    logic [GW-1:0]          gap_cnt;
    logic                   steal_en;
`endif

    function automatic logic [AGE_WIDTH-1:0] bump(input logic [AGE_WIDTH-1:0] a);
        return (a == AGE_MAX) ? a : a + 1'b1;
    endfunction

    // Fold the voice under idx into the running scan results.
    always_comb begin
        m_found_n = m_found;
        m_idx_n   = m_idx;
        f_found_n = f_found;
        f_idx_n   = f_idx;
        o_found_n = o_found;
        o_idx_n   = o_idx;
        if (!m_found && active[idx] && note[idx] == lat_note) begin
            m_found_n = 1'b1;
            m_idx_n   = idx;
        end
        if (!f_found && !active[idx]) begin
            f_found_n = 1'b1;
            f_idx_n   = idx;
        end
        if (active[idx] && (!o_found || age[idx] > age[o_idx])) begin
            o_found_n = 1'b1;
            o_idx_n   = idx;
        end
    end

    always_comb begin
        open_en   = 1'b0;
        open_idx  = m_idx_n;
        close_en  = 1'b0;
        close_idx = m_idx_n;
        ovf_en    = 1'b0;
`ifdef VOICE_STEAL_EN
        steal_en  = 1'b0;
`endif
        if (state == SCAN && idx == LAST) begin
            if (lat_on) begin
                if (m_found_n) begin
                    open_en  = 1'b1;
                    open_idx = m_idx_n;
                end else if (f_found_n) begin
                    open_en  = 1'b1;
                    open_idx = f_idx_n;
                end else begin
                    ovf_en = 1'b1;
`ifdef VOICE_STEAL_EN
                    close_en  = 1'b1;
                    close_idx = o_idx_n;
                    steal_en  = 1'b1;
`endif
                end
            end else if (m_found_n) begin
                close_en  = 1'b1;
                close_idx = m_idx_n;
            end
        end
`ifdef VOICE_STEAL_EN
        if (state == STEAL_WAIT && gap_cnt == '0) begin
            open_en  = 1'b1;
            open_idx = victim;
        end
`endif
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            idx        <= '0;
            lat_on     <= 1'b0;
            lat_note   <= '0;
            lat_incr   <= '0;
            m_found    <= 1'b0;
            f_found    <= 1'b0;
            o_found    <= 1'b0;
            m_idx      <= '0;
            f_idx      <= '0;
            o_idx      <= '0;
            active     <= '0;
            gate_open  <= '0;
            gate_close <= '0;
            overflow   <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note[v] <= '0;
                incr[v] <= '0;
                age[v]  <= '0;
            end
`ifdef VOICE_STEAL_EN
            victim  <= '0;
            gap_cnt <= '0;
`endif
        end else begin
            gate_open  <= '0;
            gate_close <= '0;
            overflow   <= ovf_en;
            case (state)
                IDLE: begin
                    if (bus.EventValid) begin
                        lat_on   <= bus.EventOn;
                        lat_note <= bus.EventNote;
                        lat_incr <= bus.EventIncr;
                        idx      <= '0;
                        m_found  <= 1'b0;
                        f_found  <= 1'b0;
                        o_found  <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    m_found <= m_found_n;
                    m_idx   <= m_idx_n;
                    f_found <= f_found_n;
                    f_idx   <= f_idx_n;
                    o_found <= o_found_n;
                    o_idx   <= o_idx_n;
                    if (idx == LAST) begin
                        state <= IDLE;
`ifdef VOICE_STEAL_EN
                        if (steal_en) begin
                            victim  <= o_idx_n;
                            gap_cnt <= GW'(STEAL_GAP - 1);
                            state   <= STEAL_WAIT;
                        end
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
`ifdef VOICE_STEAL_EN
                STEAL_WAIT: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else gap_cnt <= gap_cnt - 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase

            // Every note-on placement ages all other sounding voices.
            if (open_en) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (active[v] && IW'(v) != open_idx) age[v] <= bump(age[v]);
                end
                age[open_idx]       <= '0;
                active[open_idx]    <= 1'b1;
                note[open_idx]      <= lat_note;
                incr[open_idx]      <= lat_incr;
                gate_open[open_idx] <= 1'b1;
            end
            if (close_en) begin
                active[close_idx]     <= 1'b0;
                gate_close[close_idx] <= 1'b1;
            end
        end
    end

    always_comb begin
        incr_flat = '0;
        for (int v = 0; v < NUM_VOICES; v++) incr_flat[v*INCR_WIDTH +: INCR_WIDTH] = incr[v];
    end

    assign bus.EventReady  = (state == IDLE);
    assign bus.GateOpen    = gate_open;
    assign bus.GateClose   = gate_close;
    assign bus.VoiceIncr   = incr_flat;
    assign bus.VoiceActive = active;
    assign bus.Overflow    = overflow;
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: cycle-level behavioural model plus directed scenarios with literal expectations.
module tb_voice_allocator;
    localparam int NV  = 4;
    localparam int GAP = 2;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    voice_allocator_if #(.NUM_VOICES(NV), .NOTE_WIDTH(7), .INCR_WIDTH(8)) bus ();

    voice_allocator #(.NUM_VOICES(NV), .NOTE_WIDTH(7), .INCR_WIDTH(8), .AGE_WIDTH(4), .STEAL_GAP(GAP)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    // Behavioural model: event phase + cycles elapsed, whole-array decisions at commit time.
    int         m_phase, m_cnt, m_victim;
    logic       m_on;
    logic [6:0] m_evnote;
    logic [7:0] m_evincr;
    logic       m_act [NV];
    logic [6:0] m_note[NV];
    logic [7:0] m_incr[NV];
    int         m_age [NV];
    logic [NV-1:0] m_go, m_gc;
    logic       m_ov;

    task automatic place(input int t);
        for (int v = 0; v < NV; v++)
            if (m_act[v] && v != t && m_age[v] < 15) m_age[v]++;
        m_age[t] = 0;
        m_act[t] = 1'b1;
        m_note[t] = m_evnote;
        m_incr[t] = m_evincr;
        m_go[t] = 1'b1;
    endtask

    task automatic decide();
        int mi, fi, oi;
        mi = -1; fi = -1; oi = -1;
        for (int v = 0; v < NV; v++) begin
            if (mi < 0 && m_act[v] && m_note[v] == m_evnote) mi = v;
            if (fi < 0 && !m_act[v]) fi = v;
            if (m_act[v] && (oi < 0 || m_age[v] > m_age[oi])) oi = v;
        end
        m_phase = 0;
        if (m_on) begin
            if (mi >= 0) place(mi);
            else if (fi >= 0) place(fi);
            else begin
                m_ov = 1'b1;
`ifdef VOICE_STEAL_EN
                m_gc[oi] = 1'b1;
                m_act[oi] = 1'b0;
                m_victim = oi;
                m_phase = 2;
                m_cnt = 0;
`endif
            end
        end else if (mi >= 0) begin
            m_gc[mi] = 1'b1;
            m_act[mi] = 1'b0;
        end
    endtask

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_phase = 0; m_cnt = 0; m_victim = 0;
            m_go = '0; m_gc = '0; m_ov = 1'b0;
            for (int v = 0; v < NV; v++) begin
                m_act[v] = 1'b0; m_note[v] = '0; m_incr[v] = '0; m_age[v] = 0;
            end
        end else begin
            m_go = '0; m_gc = '0; m_ov = 1'b0;
            if (m_phase == 0) begin
                if (bus.EventValid) begin
                    m_on = bus.EventOn; m_evnote = bus.EventNote; m_evincr = bus.EventIncr;
                    m_cnt = 0; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_cnt++;
                if (m_cnt == NV) decide();
            end else begin
                m_cnt++;
                if (m_cnt == GAP) begin
                    place(m_victim);
                    m_phase = 0;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge Clock) begin
        logic [NV-1:0]   e_act;
        logic [NV*8-1:0] e_incr;
        if (!Reset) begin
            for (int v = 0; v < NV; v++) begin
                e_act[v] = m_act[v];
                e_incr[v*8 +: 8] = m_incr[v];
            end
            checks += 6;
            if (bus.EventReady !== (m_phase == 0)) begin failures++; $display("FAIL cyc_ready got=%b exp=%b t=%0t", bus.EventReady, m_phase == 0, $time); end
            if (bus.GateOpen !== m_go) begin failures++; $display("FAIL cyc_gate_open got=%b exp=%b t=%0t", bus.GateOpen, m_go, $time); end
            if (bus.GateClose !== m_gc) begin failures++; $display("FAIL cyc_gate_close got=%b exp=%b t=%0t", bus.GateClose, m_gc, $time); end
            if (bus.Overflow !== m_ov) begin failures++; $display("FAIL cyc_overflow got=%b exp=%b t=%0t", bus.Overflow, m_ov, $time); end
            if (bus.VoiceActive !== e_act) begin failures++; $display("FAIL cyc_active got=%b exp=%b t=%0t", bus.VoiceActive, e_act, $time); end
            if (bus.VoiceIncr !== e_incr) begin failures++; $display("FAIL cyc_incr got=%h exp=%h t=%0t", bus.VoiceIncr, e_incr, $time); end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (m_phase != 0 && guard < 50) begin @(negedge Clock); guard++; end
        if (guard >= 50) chk("ready_timeout", 32'(m_phase), 0);
    endtask

    task automatic send_only(input logic on, input logic [6:0] n, input logic [7:0] inc);
        @(negedge Clock);
        wait_idle();
        bus.EventValid = 1'b1; bus.EventOn = on; bus.EventNote = n; bus.EventIncr = inc;
        @(negedge Clock);
        bus.EventValid = 1'b0;
    endtask

    // Accumulates pulses from accept until EventReady returns; lat counts cycles after accept.
    task automatic send(input logic on, input logic [6:0] n, input logic [7:0] inc,
                        output logic [NV-1:0] go, output logic [NV-1:0] gc, output logic ov, output int lat);
        go = '0; gc = '0; ov = 1'b0; lat = -1;
        send_only(on, n, inc);
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) @(negedge Clock);
            go |= bus.GateOpen; gc |= bus.GateClose; ov |= bus.Overflow;
            if (bus.EventReady) begin lat = k; break; end
        end
    endtask

    task automatic reset_pulse();
        @(negedge Clock);
        #2 Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        #2 Reset = 1'b0;
    endtask

    task automatic watch_quiet(input string name);
        logic [NV-1:0] any;
        any = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            any |= bus.GateOpen | bus.GateClose | {NV{bus.Overflow}};
        end
        chk({name, "_no_pulse"}, 32'(any), 0);
        chk({name, "_active"}, 32'(bus.VoiceActive), 0);
        chk({name, "_ready"}, 32'(bus.EventReady), 1);
        chk({name, "_incr"}, bus.VoiceIncr, 0);
    endtask

    initial begin
        logic [NV-1:0] go, gc;
        logic ov;
        int lat;
        bus.EventValid = 1'b0; bus.EventOn = 1'b0; bus.EventNote = '0; bus.EventIncr = '0;
        repeat (2) @(negedge Clock);
        #2 Reset = 1'b0;
        @(negedge Clock);
        chk("rst_ready", 32'(bus.EventReady), 1);
        chk("rst_gates", 32'({bus.GateOpen, bus.GateClose, bus.Overflow}), 0);
        chk("rst_active", 32'(bus.VoiceActive), 0);
        chk("rst_incr", bus.VoiceIncr, 0);

        send(1'b1, 7'd60, 8'h0F, go, gc, ov, lat);
        chk("on60_go", 32'(go), 32'b0001);
        chk("on60_lat", 32'(lat), 5);
        chk("on60_incr", 32'(bus.VoiceIncr[7:0]), 32'h0F);
        chk("on60_active", 32'(bus.VoiceActive), 32'b0001);
        send(1'b1, 7'd62, 8'h10, go, gc, ov, lat);
        chk("on62_active", 32'(bus.VoiceActive), 32'b0011);
        send(1'b1, 7'd64, 8'h12, go, gc, ov, lat);
        chk("on64_active", 32'(bus.VoiceActive), 32'b0111);
        send(1'b1, 7'd67, 8'h15, go, gc, ov, lat);
        chk("on67_go", 32'(go), 32'b1000);
        chk("on67_active", 32'(bus.VoiceActive), 32'b1111);

        send(1'b1, 7'd72, 8'h33, go, gc, ov, lat);
`ifdef VOICE_STEAL_EN
        chk("steal_close", 32'(gc), 32'b0001);
        chk("steal_open", 32'(go), 32'b0001);
        chk("steal_ovf", 32'(ov), 1);
        chk("steal_lat", 32'(lat), 7);
        chk("steal_incr", 32'(bus.VoiceIncr[7:0]), 32'h33);
`else
        chk("full_close", 32'(gc), 0);
        chk("full_open", 32'(go), 0);
        chk("full_ovf", 32'(ov), 1);
        chk("full_lat", 32'(lat), 5);
`endif
        chk("full_active", 32'(bus.VoiceActive), 32'b1111);

        send(1'b0, 7'd64, 8'h00, go, gc, ov, lat);
        chk("off64_close", 32'(gc), 32'b0100);
        chk("off64_open", 32'(go), 0);
        chk("off64_active", 32'(bus.VoiceActive), 32'b1011);

        reset_pulse();
        send(1'b0, 7'd50, 8'h00, go, gc, ov, lat);
        chk("off50_pulses", 32'({go, gc, ov}), 0);
        chk("off50_lat", 32'(lat), 5);
        send(1'b1, 7'd40, 8'h11, go, gc, ov, lat);
        send(1'b1, 7'd60, 8'h0F, go, gc, ov, lat);
        chk("v1_go", 32'(go), 32'b0010);
        send(1'b1, 7'd60, 8'h20, go, gc, ov, lat);
        chk("retrig_go", 32'(go), 32'b0010);
        chk("retrig_incr", 32'(bus.VoiceIncr[15:8]), 32'h20);
        chk("retrig_active", 32'(bus.VoiceActive), 32'b0011);

        send_only(1'b1, 7'd70, 8'h44);
        @(negedge Clock);
        reset_pulse();
        watch_quiet("rst_scan");

        send(1'b1, 7'd60, 8'h01, go, gc, ov, lat);
        send(1'b1, 7'd62, 8'h02, go, gc, ov, lat);
        send(1'b1, 7'd64, 8'h03, go, gc, ov, lat);
        send(1'b1, 7'd67, 8'h04, go, gc, ov, lat);
        send_only(1'b1, 7'd99, 8'h55);
        repeat (4) @(negedge Clock);
        reset_pulse();
        watch_quiet("rst_steal");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
